// File: rtl/glcd_pkg.sv
// Shared definitions for the dual-controller graphic LCD bus: FSM state codes,
// controller command bytes and the per-port write payload.
package glcd_pkg;

   localparam logic [2:0] RST_HOLD = 3'd0;
   localparam logic [2:0] IDLE     = 3'd1;
   localparam logic [2:0] SETUP    = 3'd2;
   localparam logic [2:0] EN_HI    = 3'd3;
   localparam logic [2:0] HOLD     = 3'd4;

   localparam logic [7:0] DISPLAY_ON = 8'h3F;
   localparam logic [7:0] START_LINE = 8'hC0;
   localparam logic [7:0] SET_Y      = 8'h40;
   localparam logic [7:0] SET_PAGE   = 8'hB8;

   typedef struct packed {
      logic [1:0] cs;
      logic       di;
      logic [7:0] data;
   } glcd_payload_t;

   // Phase counters run 0..ticks-1, so a phase ends when the count hits ticks-1.
   function automatic logic [7:0] tick_limit(input int unsigned ticks);
      return 8'(ticks - 32'd1);
   endfunction

endpackage

// File: rtl/glcd_bus_arbiter_if.sv
// Requester handshake and LCD pin bundle; the arbiter is the slave side,
// requesters and the panel model sit on the master side.
interface glcd_bus_arbiter_if;

   logic       REQ0;
   logic [1:0] CS0;
   logic       DI0;
   logic [7:0] DATA0;
   logic       ACK0;
   logic       REQ1;
   logic [1:0] CS1_SEL;
   logic       DI1;
   logic [7:0] DATA1;
   logic       ACK1;
   logic       BUSY;
   logic       LCD_RST;
   logic       LCD_ENABLE;
   logic       LCD_RW;
   logic       LCD_DI;
   logic       LCD_CS1;
   logic       LCD_CS2;
   logic [7:0] LCD_DATA;

   modport master (
      output REQ0, CS0, DI0, DATA0, REQ1, CS1_SEL, DI1, DATA1,
      input  ACK0, ACK1, BUSY, LCD_RST, LCD_ENABLE, LCD_RW, LCD_DI,
             LCD_CS1, LCD_CS2, LCD_DATA
   );

   modport slave (
      input  REQ0, CS0, DI0, DATA0, REQ1, CS1_SEL, DI1, DATA1,
      output ACK0, ACK1, BUSY, LCD_RST, LCD_ENABLE, LCD_RW, LCD_DI,
             LCD_CS1, LCD_CS2, LCD_DATA
   );

endinterface

// File: rtl/glcd_tick_gen.sv
// Clock-enable divider: tick is high for one CLK every TICK_DIV cycles,
// aligned with the last count value.
module glcd_tick_gen #(
   parameter int unsigned TICK_DIV = 256
) (
   input  logic CLK,
   input  logic RESET,
   output logic tick
);

   localparam int unsigned   CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_nxt_s;
   logic          tick_r;

   // Wrap the divider count at TICK_DIV-1.
   always_comb begin
      if (cnt_r == LAST) begin
         cnt_nxt_s = {CW{1'b0}};
      end else begin
         cnt_nxt_s = cnt_r + CW'(1);
      end
   end

   // tick_r is registered alongside the count so it is high exactly while cnt_r==LAST.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         cnt_r  <= {CW{1'b0}};
         tick_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_nxt_s;
         tick_r <= (cnt_nxt_s == LAST);
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/glcd_bus_arbiter.sv
// Round-robin arbiter turning each granted request into one LCD write cycle
// (setup, E high, hold) timed in divider ticks; also owns the LCD reset pulse.
module glcd_bus_arbiter
   import glcd_pkg::*;
#(
   parameter int unsigned TICK_DIV    = 256,
   parameter int unsigned SETUP_TICKS = 1,
   parameter int unsigned EN_TICKS    = 2,
   parameter int unsigned HOLD_TICKS  = 1,
   parameter int unsigned RST_TICKS   = 4
) (
   input logic               CLK,
   input logic               RESET,
   glcd_bus_arbiter_if.slave bus
);

   localparam logic [7:0] RST_LIM   = tick_limit(RST_TICKS);
   localparam logic [7:0] SETUP_LIM = tick_limit(SETUP_TICKS);
   localparam logic [7:0] EN_LIM    = tick_limit(EN_TICKS);
   localparam logic [7:0] HOLD_LIM  = tick_limit(HOLD_TICKS);

   logic          tick_s;
   logic [2:0]    state_r, state_nxt_s;
   logic [7:0]    phase_cnt_r, phase_cnt_nxt_s, phase_lim_s;
   logic          phase_done_s;
   logic          prio_r, prio_nxt_s;
   logic          gnt_r, gnt_nxt_s;
   logic          sel_port_s;
   glcd_payload_t pay0_s, pay1_s, pay_sel_s;
   logic          lcd_rst_r, lcd_rst_nxt_s;
   logic          lcd_en_r, lcd_en_nxt_s;
   logic          lcd_di_r, lcd_di_nxt_s;
   logic [1:0]    lcd_cs_r, lcd_cs_nxt_s;
   logic [7:0]    lcd_data_r, lcd_data_nxt_s;
   logic          ack0_r, ack0_nxt_s;
   logic          ack1_r, ack1_nxt_s;
   logic          busy_r, busy_nxt_s;

   glcd_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .CLK   (CLK),
      .RESET (RESET),
      .tick  (tick_s)
   );

   assign pay0_s = {bus.CS0, bus.DI0, bus.DATA0};
   assign pay1_s = {bus.CS1_SEL, bus.DI1, bus.DATA1};

   // Port selection: on a tie prio_r names the port not granted last.
   always_comb begin
      if (bus.REQ0 && bus.REQ1) begin
         sel_port_s = prio_r;
      end else if (bus.REQ1) begin
         sel_port_s = 1'b1;
      end else begin
         sel_port_s = 1'b0;
      end
      pay_sel_s = sel_port_s ? pay1_s : pay0_s;
   end

   // Tick budget of the current phase.
   always_comb begin
      case (state_r)
         RST_HOLD: phase_lim_s = RST_LIM;
         SETUP:    phase_lim_s = SETUP_LIM;
         EN_HI:    phase_lim_s = EN_LIM;
         HOLD:     phase_lim_s = HOLD_LIM;
         default:  phase_lim_s = 8'd0;
      endcase
      phase_done_s = (phase_cnt_r == phase_lim_s);
   end

   // Next-state and output logic; everything advances only on tick cycles.
   always_comb begin
      state_nxt_s     = state_r;
      phase_cnt_nxt_s = phase_cnt_r;
      prio_nxt_s      = prio_r;
      gnt_nxt_s       = gnt_r;
      lcd_rst_nxt_s   = lcd_rst_r;
      lcd_en_nxt_s    = lcd_en_r;
      lcd_di_nxt_s    = lcd_di_r;
      lcd_cs_nxt_s    = lcd_cs_r;
      lcd_data_nxt_s  = lcd_data_r;
      ack0_nxt_s      = 1'b0;
      ack1_nxt_s      = 1'b0;
      if (tick_s) begin
         phase_cnt_nxt_s = phase_done_s ? 8'd0 : (phase_cnt_r + 8'd1);
         case (state_r)
            RST_HOLD: begin
               if (phase_done_s) begin
                  lcd_rst_nxt_s = 1'b1;
                  state_nxt_s   = IDLE;
               end else begin
                  state_nxt_s = RST_HOLD;
               end
            end
            IDLE: begin
               phase_cnt_nxt_s = 8'd0;
               if (bus.REQ0 || bus.REQ1) begin
                  gnt_nxt_s      = sel_port_s;
                  prio_nxt_s     = ~sel_port_s;
                  lcd_cs_nxt_s   = pay_sel_s.cs;
                  lcd_di_nxt_s   = pay_sel_s.di;
                  lcd_data_nxt_s = pay_sel_s.data;
                  state_nxt_s    = SETUP;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            SETUP: begin
               if (phase_done_s) begin
                  lcd_en_nxt_s = 1'b1;
                  state_nxt_s  = EN_HI;
               end else begin
                  state_nxt_s = SETUP;
               end
            end
            EN_HI: begin
               if (phase_done_s) begin
                  lcd_en_nxt_s = 1'b0;
                  state_nxt_s  = HOLD;
               end else begin
                  state_nxt_s = EN_HI;
               end
            end
            HOLD: begin
               if (phase_done_s) begin
                  ack0_nxt_s   = ~gnt_r;
                  ack1_nxt_s   = gnt_r;
                  lcd_cs_nxt_s = 2'b00;
                  state_nxt_s  = IDLE;
               end else begin
                  state_nxt_s = HOLD;
               end
            end
            default: begin
               // Unreachable encoding: park the pins and replay the LCD reset.
               phase_cnt_nxt_s = 8'd0;
               lcd_rst_nxt_s   = 1'b0;
               lcd_en_nxt_s    = 1'b0;
               lcd_cs_nxt_s    = 2'b00;
               state_nxt_s     = RST_HOLD;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
      busy_nxt_s = (state_nxt_s != IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_r     <= RST_HOLD;
         phase_cnt_r <= 8'd0;
         prio_r      <= 1'b0;
         gnt_r       <= 1'b0;
         lcd_rst_r   <= 1'b0;
         lcd_en_r    <= 1'b0;
         lcd_di_r    <= 1'b0;
         lcd_cs_r    <= 2'b00;
         lcd_data_r  <= 8'h00;
         ack0_r      <= 1'b0;
         ack1_r      <= 1'b0;
         busy_r      <= 1'b1;
      end else begin
         state_r     <= state_nxt_s;
         phase_cnt_r <= phase_cnt_nxt_s;
         prio_r      <= prio_nxt_s;
         gnt_r       <= gnt_nxt_s;
         lcd_rst_r   <= lcd_rst_nxt_s;
         lcd_en_r    <= lcd_en_nxt_s;
         lcd_di_r    <= lcd_di_nxt_s;
         lcd_cs_r    <= lcd_cs_nxt_s;
         lcd_data_r  <= lcd_data_nxt_s;
         ack0_r      <= ack0_nxt_s;
         ack1_r      <= ack1_nxt_s;
         busy_r      <= busy_nxt_s;
      end
   end

   assign bus.ACK0       = ack0_r;
   assign bus.ACK1       = ack1_r;
   assign bus.BUSY       = busy_r;
   assign bus.LCD_RST    = lcd_rst_r;
   assign bus.LCD_ENABLE = lcd_en_r;
   assign bus.LCD_RW     = 1'b0;
   assign bus.LCD_DI     = lcd_di_r;
   assign bus.LCD_CS1    = lcd_cs_r[0];
   assign bus.LCD_CS2    = lcd_cs_r[1];
   assign bus.LCD_DATA   = lcd_data_r;

endmodule
